// File: rtl/buzzer_tone_gen.sv
// PWM tone engine behind the buzzer register file: plays a square wave for a
// programmed number of ticks (one-shot) or until stopped (continuous).
module buzzer_tone_gen #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TICK_DIV           = 100000
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          ctrl_en,
    input  logic                          ctrl_mode,
    input  logic                          start,
    input  logic                          stop,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] period,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] duty,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] duration,
    output logic                          buzzer_out,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err,
    output logic [C_S_AXI_DATA_WIDTH-1:0] remaining
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   period_q, period_d;
    logic [DW-1:0]   duty_q, duty_d;
    logic [DW-1:0]   dur_q, dur_d;
    logic            mode_q, mode_d;
    logic [DW-1:0]   phase_q, phase_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [DW-1:0]   remaining_q, remaining_d;
    logic            buzzer_q, buzzer_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            cfg_err_q, cfg_err_d;
    logic            abort;

    // start/stop are single-cycle strobes from register writes; stop always wins.
    assign abort = stop || !ctrl_en;

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        duty_d      = duty_q;
        dur_d       = dur_q;
        mode_d      = mode_q;
        phase_d     = phase_q;
        presc_d     = presc_q;
        remaining_d = remaining_q;
        buzzer_d    = 1'b0;
        cfg_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!stop && start && ctrl_en) begin
                    // Capture on the accepting edge so the latched copy is the validated one.
                    if (period >= DW'(2) && duty != '0) begin
                        state_d  = S_LOAD;
                        period_d = period;
                        duty_d   = (duty >= period) ? (period - DW'(1)) : duty;
                        dur_d    = duration;
                        mode_d   = ctrl_mode;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                phase_d = '0;
                presc_d = '0;
                if (abort) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                end else if (!mode_q && dur_q == '0) begin
                    state_d     = S_DONE;
                    remaining_d = '0;
                end else begin
                    state_d     = S_PLAY;
                    remaining_d = mode_q ? '0 : dur_q;
                end
            end
            S_PLAY: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                end else begin
                    phase_d  = (phase_q == period_q - DW'(1)) ? '0 : phase_q + DW'(1);
                    presc_d  = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
                    buzzer_d = (phase_q < duty_q);
                    if (presc_q == PRESC_LAST && !mode_q) begin
                        if (remaining_q <= DW'(1)) begin
                            remaining_d = '0;
                            state_d     = S_DONE;
                            buzzer_d    = 1'b0;
                        end else begin
                            remaining_d = remaining_q - DW'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_PLAY);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            period_q    <= '0;
            duty_q      <= '0;
            dur_q       <= '0;
            mode_q      <= 1'b0;
            phase_q     <= '0;
            presc_q     <= '0;
            remaining_q <= '0;
            buzzer_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            duty_q      <= duty_d;
            dur_q       <= dur_d;
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            presc_q     <= presc_d;
            remaining_q <= remaining_d;
            buzzer_q    <= buzzer_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign buzzer_out = buzzer_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;
    assign remaining  = remaining_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen with TICK_DIV=10: start acceptance table,
// waveform table, and hand sequences for one-shot, zero duration, mid-play and reset.
module tb_buzzer_tone_gen;

    localparam int DW = 32;

    logic          ACLK;
    logic          ARESETN;
    logic          ctrl_en;
    logic          ctrl_mode;
    logic          start;
    logic          stop;
    logic [DW-1:0] period;
    logic [DW-1:0] duty;
    logic [DW-1:0] duration;
    logic          buzzer_out;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [DW-1:0] remaining;

    int tests;
    int failures;

    buzzer_tone_gen #(.C_S_AXI_DATA_WIDTH(DW), .TICK_DIV(10)) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .ctrl_en    (ctrl_en),
        .ctrl_mode  (ctrl_mode),
        .start      (start),
        .stop       (stop),
        .period     (period),
        .duty       (duty),
        .duration   (duration),
        .buzzer_out (buzzer_out),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .remaining  (remaining)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic          en;
        logic          mode;
        logic          st;
        logic          sp;
        logic [DW-1:0] per;
        logic [DW-1:0] dty;
        logic          exp_err;
        logic          exp_busy;
    } acc_vec_t;

    typedef struct {
        logic [DW-1:0] per;
        logic [DW-1:0] dty;
        int            exp_high;
        int            ncyc;
    } wave_vec_t;

    acc_vec_t  acc_tbl[9];
    wave_vec_t wave_tbl[6];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge ACLK);
        #1 start = 1'b1;
        @(posedge ACLK);
        #1 start = 1'b0;
    endtask

    // Called at a negedge: stop is seen by the next posedge, engine idle after it.
    task automatic stop_and_check(input string tag);
        stop = 1'b1;
        @(posedge ACLK);
        #1 stop = 1'b0;
        @(negedge ACLK);
        check({tag, "_stop_buzzer"}, {31'd0, buzzer_out}, 0);
        check({tag, "_stop_busy"}, {31'd0, busy}, 0);
        check({tag, "_stop_done"}, {31'd0, done}, 0);
    endtask

    initial begin
        int bad;
        int dn;
        int highs;
        int done_at;
        int done_cnt;
        int rem10;
        int rem39;
        int p;

        tests     = 0;
        failures  = 0;
        ARESETN   = 1'b0;
        ctrl_en   = 1'b1;
        ctrl_mode = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        period    = 8;
        duty      = 3;
        duration  = 4;

        //              en    mode  start stop  per  duty  err   busy
        acc_tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8,   3,   1'b0, 1'b1};
        acc_tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 8,   0,   1'b1, 1'b0};
        acc_tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1,   3,   1'b1, 1'b0};
        acc_tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 0,   3,   1'b1, 1'b0};
        acc_tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 8,   3,   1'b0, 1'b0};
        acc_tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,   0,   1'b0, 1'b0};
        acc_tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 8,   3,   1'b0, 1'b0};
        acc_tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1,   0,   1'b0, 1'b0};
        acc_tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 2,   1,   1'b0, 1'b1};

        //               per  duty high ncyc
        wave_tbl[0] = '{8,   3,   3,   32};
        wave_tbl[1] = '{4,   9,   3,   16};
        wave_tbl[2] = '{6,   3,   3,   210};
        wave_tbl[3] = '{5,   1,   1,   20};
        wave_tbl[4] = '{3,   2,   2,   12};
        wave_tbl[5] = '{2,   5,   1,   10};

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_buzzer", {31'd0, buzzer_out}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_cfg_err", {31'd0, cfg_err}, 0);
        check("rst_remaining", remaining, 0);
        ARESETN = 1'b1;

        // Start acceptance / rejection table
        for (int i = 0; i < 9; i++) begin
            @(posedge ACLK);
            #1;
            ctrl_en   = acc_tbl[i].en;
            ctrl_mode = acc_tbl[i].mode;
            period    = acc_tbl[i].per;
            duty      = acc_tbl[i].dty;
            start     = acc_tbl[i].st;
            stop      = acc_tbl[i].sp;
            @(posedge ACLK);
            #1;
            start = 1'b0;
            stop  = 1'b0;
            @(negedge ACLK);
            check($sformatf("acc%0d_cfg_err", i), {31'd0, cfg_err}, {31'd0, acc_tbl[i].exp_err});
            check($sformatf("acc%0d_busy", i), {31'd0, busy}, {31'd0, acc_tbl[i].exp_busy});
            ctrl_en = 1'b1;
            stop_and_check($sformatf("acc%0d", i));
            check($sformatf("acc%0d_err_drop", i), {31'd0, cfg_err}, 0);
        end

        // Continuous waveform table
        ctrl_en   = 1'b1;
        ctrl_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            period = wave_tbl[i].per;
            duty   = wave_tbl[i].dty;
            p      = int'(wave_tbl[i].per);
            pulse_start();
            @(negedge ACLK);
            check($sformatf("wave%0d_load_busy", i), {31'd0, busy}, 1);
            @(negedge ACLK);
            check($sformatf("wave%0d_latency", i), {31'd0, buzzer_out}, 0);
            bad = 0;
            dn  = 0;
            for (int k = 0; k < wave_tbl[i].ncyc; k++) begin
                @(negedge ACLK);
                if (buzzer_out !== (((k % p) < wave_tbl[i].exp_high) ? 1'b1 : 1'b0)) bad++;
                if (done !== 1'b0) dn++;
            end
            check($sformatf("wave%0d_bad_cycles", i), bad, 0);
            check($sformatf("wave%0d_done_cnt", i), dn, 0);
            check($sformatf("wave%0d_remaining", i), remaining, 0);
            check($sformatf("wave%0d_busy", i), {31'd0, busy}, 1);
            stop_and_check($sformatf("wave%0d", i));
        end

        // One-shot: period 8, duty 3, 4 ticks -> done 40 cycles after PLAY entry
        ctrl_mode = 1'b0;
        period    = 8;
        duty      = 3;
        duration  = 4;
        pulse_start();
        @(negedge ACLK);
        @(negedge ACLK);
        check("os_entry_remaining", remaining, 4);
        check("os_entry_busy", {31'd0, busy}, 1);
        highs    = 0;
        done_at  = -1;
        done_cnt = 0;
        rem10    = -1;
        rem39    = -1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge ACLK);
            if (buzzer_out === 1'b1) highs++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k == 10) rem10 = int'(remaining);
            if (k == 39) rem39 = int'(remaining);
            if (k == 40) begin
                check("os_done_remaining", remaining, 0);
                check("os_done_busy", {31'd0, busy}, 0);
                check("os_done_buzzer", {31'd0, buzzer_out}, 0);
            end
        end
        check("os_done_at", done_at, 40);
        check("os_done_pulses", done_cnt, 1);
        check("os_high_cycles", highs, 15);
        check("os_remaining_k10", rem10, 3);
        check("os_remaining_k39", rem39, 1);

        // Zero-duration one-shot
        duration = 0;
        pulse_start();
        highs = 0;
        @(negedge ACLK);
        if (buzzer_out === 1'b1) highs++;
        check("zd_load_busy", {31'd0, busy}, 1);
        check("zd_load_done", {31'd0, done}, 0);
        @(negedge ACLK);
        if (buzzer_out === 1'b1) highs++;
        check("zd_done", {31'd0, done}, 1);
        check("zd_done_busy", {31'd0, busy}, 0);
        @(negedge ACLK);
        if (buzzer_out === 1'b1) highs++;
        check("zd_done_drop", {31'd0, done}, 0);
        check("zd_high_cycles", highs, 0);

        // Mid-play register rewrite and restart, then ctrl_en abort
        period   = 8;
        duty     = 3;
        duration = 20;
        pulse_start();
        @(negedge ACLK);
        @(negedge ACLK);
        bad = 0;
        for (int k = 0; k < 48; k++) begin
            @(negedge ACLK);
            if (buzzer_out !== (((k % 8) < 3) ? 1'b1 : 1'b0)) bad++;
            if (k == 10) begin
                period = 5;
                duty   = 4;
                start  = 1'b1;
            end
            if (k == 11) start = 1'b0;
        end
        check("mid_bad_cycles", bad, 0);
        check("mid_remaining", remaining, 16);
        ctrl_en = 1'b0;
        @(posedge ACLK);
        #1;
        @(negedge ACLK);
        check("mid_abort_busy", {31'd0, busy}, 0);
        check("mid_abort_buzzer", {31'd0, buzzer_out}, 0);
        check("mid_abort_remaining", remaining, 0);
        ctrl_en = 1'b1;
        dn = 0;
        for (int k = 0; k < 5; k++) begin
            if (done !== 1'b0) dn++;
            @(negedge ACLK);
        end
        check("mid_abort_no_done", dn, 0);

        // Asynchronous reset mid-tone, then a fresh start
        period   = 8;
        duty     = 3;
        duration = 4;
        pulse_start();
        @(negedge ACLK);
        @(negedge ACLK);
        @(negedge ACLK);
        check("ar_pre_buzzer", {31'd0, buzzer_out}, 1);
        #2 ARESETN = 1'b0;
        #1;
        check("ar_buzzer", {31'd0, buzzer_out}, 0);
        check("ar_busy", {31'd0, busy}, 0);
        check("ar_remaining", remaining, 0);
        check("ar_done", {31'd0, done}, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        pulse_start();
        @(negedge ACLK);
        check("ar_restart_busy", {31'd0, busy}, 1);
        @(negedge ACLK);
        check("ar_restart_latency", {31'd0, buzzer_out}, 0);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge ACLK);
            if (buzzer_out !== (((k % 8) < 3) ? 1'b1 : 1'b0)) bad++;
        end
        check("ar_restart_bad_cycles", bad, 0);
        stop_and_check("ar");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
